// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a resettable word memory.
// Ports: clk, rstn | psel penable pwrite paddr pwdata -> prdata pready pslverr.
// Optional APB_SLV_ERR_EN: pslverr on out-of-range or writes at/above RO_BASE.
module apb_slave_mem #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 0,
  parameter int RO_BASE     = 'hF0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

`ifdef APB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rng_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic          setup;
  logic          in_rng;
  logic          ro_hit;
  logic          err_d;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_q;

  assign setup  = psel & ~penable;
  assign in_rng = 32'(paddr) < 32'(MEM_DEPTH);
  assign ro_hit = 32'(paddr) >= 32'(RO_BASE);
  // Error decision is made at setup so later bus changes cannot alter it.
  assign err_d  = ERR_EN & (~in_rng | (pwrite & ro_hit));
  assign idx    = paddr[IW-1:0];
  assign idx_q  = addr_q[IW-1:0];

  assign pready = (state == ACCESS) && (cnt == 4'd0)
                  && psel && penable;
  assign pslverr = pready & err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rng_q   <= 1'b0;
      err_q   <= 1'b0;
      prdata  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          // psel & penable without a setup phase is ignored.
          if (setup) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            rng_q   <= in_rng;
            err_q   <= err_d;
            cnt     <= 4'(WAIT_CYCLES);
            prdata  <= in_rng ? mem[idx] : '0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (penable) begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              if (write_q && rng_q && !err_q) begin
                mem[idx_q] <= wdata_q;
              end
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
